sync_fifo_param: RTL

Parametrised single-clock FIFO, the successor to the fixed 8x140 dual-clock FIFO, for buffering inside one clock domain. Width, depth and almost-full/almost-empty thresholds are configurable. Adds an occupancy count, almost-full/almost-empty flags, a synchronous flush and sticky overflow/underflow error flags. The read side is show-ahead: the head word is visible without a read strobe, and the output is zero when the FIFO is empty.

---
 rtl/sync_fifo_param.sv | 119 +++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock show-ahead FIFO with level, almost flags and flush.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module sync_fifo_param #(
    parameter int DATA_W     = 140,
    parameter int DEPTH_LOG2 = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  fifo_clr,
    input  logic                  fifo_w_enable,
    input  logic                  fifo_r_enable,
    input  logic [DATA_W-1:0]     data_to_fifo,
    output logic [DATA_W-1:0]     data_from_fifo,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow
);

    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PTR_W-1:0] DEPTH_LVL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_LVL    = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_LVL    = PTR_W'(AE_LEVEL);
    localparam logic [PTR_W-1:0] ONE       = PTR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W-1:0]  level_q, level_d;
    logic              wr_accept;
    logic              rd_accept;

    assign fifo_empty        = (level_q == '0);
    assign fifo_full         = (level_q == DEPTH_LVL);
    assign fifo_almost_full  = (level_q >= AF_LVL);
    assign fifo_almost_empty = (level_q <= AE_LVL);
    assign fifo_level        = level_q;

    // Acceptance uses the pre-edge flags: no write-through when full, no bypass when empty.
    assign wr_accept = fifo_w_enable && !fifo_full;
    assign rd_accept = fifo_r_enable && !fifo_empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (fifo_clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (wr_accept) wptr_d = wptr_q + ONE;
            if (rd_accept) rptr_d = rptr_q + ONE;
            case ({wr_accept, rd_accept})
                2'b10:   level_d = level_q + ONE;
                2'b01:   level_d = level_q - ONE;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage is deliberately left out of reset; empty masking hides stale words.
    always_ff @(posedge clk_in) begin
        if (wr_accept && !fifo_clr) begin
            mem_q[wptr_q[DEPTH_LOG2-1:0]] <= data_to_fifo;
        end
    end

    assign data_from_fifo = fifo_empty ? '0 : mem_q[rptr_q[DEPTH_LOG2-1:0]];

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  || (fifo_w_enable && fifo_full);
        underflow_d = underflow_q || (fifo_r_enable && fifo_empty);
        if (fifo_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign fifo_overflow  = overflow_q;
    assign fifo_underflow = underflow_q;
`else
    assign fifo_overflow  = 1'b0;
    assign fifo_underflow = 1'b0;
`endif

endmodule
